// File: rtl/bus_ctrl_pkg.sv
// Shared constants for the cpu-side memory/IO slave: address map, status bit positions,
// UART transmitter state encodings and the read-path source select.
package bus_ctrl_pkg;

  localparam logic [15:0] ADDR_X0        = 16'h0000;
  localparam logic [15:0] ADDR_UART_DATA = 16'hFF00;
  localparam logic [15:0] ADDR_UART_STAT = 16'hFF04;

  localparam int STAT_FULL     = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_OVERFLOW = 2;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_STAT = 2'd2
  } rd_sel_t;

endpackage

// File: rtl/bus_ctrl_uart.sv
// UART transmitter: byte FIFO feeding an 8N1 shifter with a CLK_DIV baud counter.
// Frames chain STOP->START without an idle bit while the FIFO has data.
module uart_tx_fifo
  import bus_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          empty;
  logic          pop;
  logic          do_push;
  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic          baud_done;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign baud_done = (baud_cnt == CW'(CLK_DIV - 1));
  assign pop       = !empty && ((state == TX_IDLE) || (state == TX_STOP && baud_done));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push && (!full || pop);
  assign busy      = (state != TX_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
      case (state)
        TX_IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            state <= TX_START;
            shreg <= mem[rd_ptr[PW-1:0]];
          end
        end
        TX_START: begin
          if (baud_done) begin
            state   <= TX_DATA;
            bit_cnt <= '0;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            if (!empty) begin
              state <= TX_START;
              shreg <= mem[rd_ptr[PW-1:0]];
            end else begin
              state <= TX_IDLE;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  // Decoded straight from flops so the line goes high the moment reset asserts.
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/bus_ctrl.sv
// Single-beat memory/IO slave for the cpu: address decode, word RAM, fixed-latency read
// pipeline, UART transmitter and a sticky fault flag for decode and protocol errors.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int    RAM_WORDS    = 4096,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "prog.hex",
  parameter int    CLK_DIV      = 104,
  parameter int    FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        uart_tx,
  output logic        fault
);

  localparam int AW = $clog2(RAM_WORDS);
  // INIT_FILE names the boot image for the memory initialisation flow; RAM is never reset.
  localparam bit unused_has_image = (INIT_FILE != "");

  logic [13:0] word;
  logic        is_x0, is_ram, is_udata, is_stat, is_bad;
  rd_sel_t     sel;
  logic [2:0]  stat;
  logic        uart_full, uart_busy, uart_ovf;
  logic        rd_busy, rd_accept;
  logic unused_addr_lsbs;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_q;
  logic [READ_LATENCY-1:0] vld_pipe;
  rd_sel_t     sel_pipe [READ_LATENCY];
  logic [2:0]  stat_q;
  logic [31:0] rd_word;

  assign word              = addr[15:2];
  assign unused_addr_lsbs  = ^addr[1:0];

  always_comb begin
    is_x0    = (word == ADDR_X0[15:2]);
    is_udata = (word == ADDR_UART_DATA[15:2]);
    is_stat  = (word == ADDR_UART_STAT[15:2]);
    is_ram   = !is_x0 && !is_udata && !is_stat && ({18'd0, word} < 32'(RAM_WORDS));
    is_bad   = !(is_x0 || is_ram || is_udata || is_stat);
    sel      = SEL_ZERO;
    if (is_ram) sel = SEL_RAM;
    else if (is_stat) sel = SEL_STAT;
  end

  always_comb begin
    stat                = '0;
    stat[STAT_FULL]     = uart_full;
    stat[STAT_BUSY]     = uart_busy;
    stat[STAT_OVERFLOW] = uart_ovf;
  end

  // One read in flight at a time; a request while the pipe is occupied is dropped.
  assign rd_busy   = |vld_pipe;
  assign rd_accept = rd_en && !rd_busy;

  // Read and write in one block gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram[addr[AW+1:2]] <= wr_data;
    if (rd_accept && is_ram) ram_q <= ram[addr[AW+1:2]];
  end

  always_comb begin
    rd_word = '0;
    case (sel_pipe[READ_LATENCY-1])
      SEL_RAM:  rd_word = ram_q;
      SEL_STAT: rd_word = {29'd0, stat_q};
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) sel_pipe[i] <= SEL_ZERO;
      stat_q   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      fault    <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_accept;
      sel_pipe[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
      end
      if (rd_accept) stat_q <= stat;
      rd_valid <= vld_pipe[READ_LATENCY-1];
      if (vld_pipe[READ_LATENCY-1]) rd_data <= rd_word;
      if ((rd_en && (rd_busy || is_bad)) || (wr_en && is_bad)) fault <= 1'b1;
    end
  end

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_en && is_udata),
    .din      (wr_data[7:0]),
    .full     (uart_full),
    .busy     (uart_busy),
    .overflow (uart_ovf),
    .uart_tx  (uart_tx)
  );

endmodule
